// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: gray/binary pointer conversion and default synchroniser depth.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PTR_MAX_W       = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Pointers are passed zero-extended; w selects how many low bits are meaningful.
    function automatic ptr_word_t bin2gray(input ptr_word_t b, input int w);
        ptr_word_t m;
        m = b & ((w >= PTR_MAX_W) ? '1 : ((ptr_word_t'(1) << w) - ptr_word_t'(1)));
        return m ^ (m >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g, input int w);
        ptr_word_t b;
        logic      acc;
        b   = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W-1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the dual-clock FIFO: write pointer in, pop request, RAM address and flags out.
// rd_level exists only when FIFO_RD_LEVEL_EN is defined.
interface fifo_rd_ctrl_if #(parameter int ADDR_LEN = 4);

    logic [ADDR_LEN:0]   wr_ptr_gray;
    logic                rd_en;
    logic [ADDR_LEN-1:0] rd_addr;
    logic [ADDR_LEN:0]   rd_ptr_gray;
    logic                empty;
    logic                underflow;
`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_LEN:0]   rd_level;

    modport master (output wr_ptr_gray, rd_en,
                    input  rd_addr, rd_ptr_gray, empty, underflow, rd_level);
    modport slave  (input  wr_ptr_gray, rd_en,
                    output rd_addr, rd_ptr_gray, empty, underflow, rd_level);
`else
    modport master (output wr_ptr_gray, rd_en,
                    input  rd_addr, rd_ptr_gray, empty, underflow);
    modport slave  (input  wr_ptr_gray, rd_en,
                    output rd_addr, rd_ptr_gray, empty, underflow);
`endif

endinterface

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing clock domains.
// Pure flop chain, no logic between stages; shared by read and write sides.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: syncs the write gray pointer, owns the read pointers,
// drives the RAM read address and a registered empty flag. FIFO_RD_LEVEL_EN adds a registered rd_level.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_LEN    = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    fifo_rd_ctrl_if.slave  bus
);

    localparam int PW = ADDR_LEN + 1;

    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_nxt;
    logic [PW-1:0] rd_gray_nxt;
    logic [PW-1:0] rd_gray_q;
    logic          empty_q;
    logic          pop;

    gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.wr_ptr_gray),
        .q       (wr_gray_s)
    );

    assign pop = bus.rd_en & ~empty_q;

    always_comb begin
        rd_bin_nxt  = rd_bin + PW'(pop);
        rd_gray_nxt = PW'(bin2gray(ptr_word_t'(rd_bin_nxt), PW));
    end

    // Empty looks at the post-pop pointer so popping the last entry flags empty on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bin    <= '0;
            rd_gray_q <= '0;
            empty_q   <= 1'b1;
        end else begin
            rd_bin    <= rd_bin_nxt;
            rd_gray_q <= rd_gray_nxt;
            empty_q   <= (rd_gray_nxt == wr_gray_s);
        end
    end

    assign bus.rd_addr     = rd_bin[ADDR_LEN-1:0];
    assign bus.rd_ptr_gray = rd_gray_q;
    assign bus.empty       = empty_q;
    assign bus.underflow   = bus.rd_en & empty_q & reset_n;

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] level_q;

    always_comb begin
        wr_bin_s = PW'(gray2bin(ptr_word_t'(wr_gray_s), PW));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_q <= '0;
        else          level_q <= wr_bin_s - rd_bin_nxt;
    end

    assign bus.rd_level = level_q;
`endif

`ifndef SYNTHESIS
    // The gray pointer feeds another clock domain, so it may only ever move by one bit.
    a_gray_one_bit: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(rd_gray_q ^ $past(rd_gray_q)));
    a_underflow_hold: assert property (@(posedge clk) disable iff (!reset_n)
        bus.underflow |=> (rd_bin == $past(rd_bin)));
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised self-checking bench for fifo_rd_ctrl against a pointer-count model of the read side.
// Build with FIFO_RD_LEVEL_EN defined to also check rd_level.
module tb_fifo_rd_ctrl;

    localparam int AL    = 4;
    localparam int S     = 2;
    localparam int PW    = AL + 1;
    localparam int MOD   = 1 << PW;
    localparam int DEPTH = 1 << AL;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.ADDR_LEN(AL)) bus();

    fifo_rd_ctrl #(.ADDR_LEN(AL), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int wcnt     = 0;

    // Model: entries written, entries popped, and the write count as the read side currently sees it.
    int m_rcnt  = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    int whist[S];

    int prev_g     = 0;
    bit prev_valid = 1'b0;
    bit saw_wrap   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_w(input int n);
        wcnt = n % MOD;
        bus.wr_ptr_gray = PW'(wcnt ^ (wcnt >> 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int room();
        return DEPTH - ((wcnt - m_rcnt + MOD) % MOD);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int seen;
        if (!reset_n) begin
            m_rcnt  = 0;
            m_empty = 1'b1;
            m_level = 0;
            for (int i = 0; i < S; i++) whist[i] = 0;
        end else begin
            seen = whist[S-1];
            if (bus.rd_en && !m_empty) m_rcnt = (m_rcnt + 1) % MOD;
            m_level = (seen - m_rcnt + MOD) % MOD;
            m_empty = (m_level == 0);
            for (int i = S-1; i > 0; i--) whist[i] = whist[i-1];
            whist[0] = wcnt;
        end
    end

    always @(negedge clk) begin
        int cur;
        chk("rd_addr",     32'(bus.rd_addr),     32'(m_rcnt % DEPTH));
        chk("rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'(m_rcnt ^ (m_rcnt >> 1)));
        chk("empty",       32'(bus.empty),       32'(m_empty));
        chk("underflow",   32'(bus.underflow),   32'(reset_n & bus.rd_en & m_empty));
`ifdef FIFO_RD_LEVEL_EN
        chk("rd_level",    32'(bus.rd_level),    32'(m_level));
`endif
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            cur = int'(bus.rd_ptr_gray);
            if (prev_valid && cur != prev_g) begin
                chk("gray_one_bit", 32'($countones(cur ^ prev_g)), 32'd1);
                if (prev_g == 16) begin
                    chk("gray_wrap_to_zero", 32'(cur), 32'd0);
                    saw_wrap = 1'b1;
                end
            end
            prev_g     = cur;
            prev_valid = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int writes;
        bus.rd_en = 1'b0;
        set_w(0);
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_empty",     32'(bus.empty),       32'd1);
        chk("rst_rd_addr",   32'(bus.rd_addr),     32'd0);
        chk("rst_gray",      32'(bus.rd_ptr_gray), 32'd0);
        chk("rst_underflow", 32'(bus.underflow),   32'd0);
        reset_n = 1'b1;
        tick();

        // First write becomes visible after SYNC_STAGES edges; then one pop empties it again.
        set_w(1);
        tick();
        tick();
        chk("lat_empty_edge1", 32'(bus.empty), 32'd1);
        tick();
        chk("lat_empty_edge2", 32'(bus.empty), 32'd0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("pop_rd_addr", 32'(bus.rd_addr),     32'd1);
        chk("pop_gray",    32'(bus.rd_ptr_gray), 32'b00001);
        chk("pop_empty",   32'(bus.empty),       32'd1);

        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("uf_pulse",   32'(bus.underflow),   32'd1);
            chk("uf_rd_addr", 32'(bus.rd_addr),     32'd1);
            chk("uf_gray",    32'(bus.rd_ptr_gray), 32'b00001);
            tick();
        end
        bus.rd_en = 1'b0;
        #1;
        chk("uf_clear", 32'(bus.underflow), 32'd0);

        // Two entries present, then pop on the edge where a third write arrives from the synchroniser.
        set_w(2);
        tick();
        set_w(3);
        repeat (3) tick();
        chk("sim_pre_empty", 32'(bus.empty), 32'd0);
        set_w(4);
        tick();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("sim_empty", 32'(bus.empty), 32'd0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 20 && !bus.empty; i++) tick();
        bus.rd_en = 1'b0;
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Streaming 40 entries with continuous pops carries the pointer through its wrap.
        saw_wrap  = 1'b0;
        done      = 1'b0;
        writes    = 0;
        bus.rd_en = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            if (writes < 40 && room() > 0) begin
                set_w(wcnt + 1);
                writes++;
            end
            tick();
            if (writes == 40 && m_rcnt == wcnt) done = 1'b1;
        end
        bus.rd_en = 1'b0;
        chk("wrap_done", 32'(done),     32'd1);
        chk("wrap_seen", 32'(saw_wrap), 32'd1);
        repeat (S + 1) tick();

        // Fill to depth without popping, then pop everything back out.
        for (int i = 0; i < DEPTH; i++) begin
            set_w(wcnt + 1);
            tick();
        end
        repeat (S + 1) tick();
        chk("full_empty", 32'(bus.empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk("full_level", 32'(bus.rd_level), 32'd16);
`endif
        bus.rd_en = 1'b1;
        repeat (DEPTH) tick();
        bus.rd_en = 1'b0;
        chk("drained_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
        chk("drained_level", 32'(bus.rd_level), 32'd0);
`endif

        // Reset in the middle of traffic clears everything without waiting for a clock edge.
        for (int i = 0; i < 5; i++) begin
            set_w(wcnt + 1);
            tick();
        end
        bus.rd_en = 1'b1;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_empty",     32'(bus.empty),       32'd1);
        chk("mid_rst_rd_addr",   32'(bus.rd_addr),     32'd0);
        chk("mid_rst_gray",      32'(bus.rd_ptr_gray), 32'd0);
        chk("mid_rst_underflow", 32'(bus.underflow),   32'd0);
        bus.rd_en = 1'b0;
        set_w(0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        for (int c = 0; c < 800; c++) begin
            bus.rd_en = 1'($urandom_range(0, 1));
            if (room() > 0 && $urandom_range(0, 1) == 1) set_w(wcnt + 1);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                bus.rd_en = 1'b0;
                set_w(0);
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        bus.rd_en = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
